// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle controller: instruction codes, FSM states,
// ALU operations, datapath mux selects and the decoded-control bundle.
package mc_controller_pkg;

  localparam logic [5:0] INST_NOP  = 6'd0;
  localparam logic [5:0] INST_ADDU = 6'd1;
  localparam logic [5:0] INST_SUBU = 6'd2;
  localparam logic [5:0] INST_SLT  = 6'd3;
  localparam logic [5:0] INST_SRAV = 6'd4;
  localparam logic [5:0] INST_ADDI = 6'd5;
  localparam logic [5:0] INST_ORI  = 6'd6;
  localparam logic [5:0] INST_LUI  = 6'd7;
  localparam logic [5:0] INST_LW   = 6'd8;
  localparam logic [5:0] INST_LB   = 6'd9;
  localparam logic [5:0] INST_SW   = 6'd10;
  localparam logic [5:0] INST_SB   = 6'd11;
  localparam logic [5:0] INST_BEQ  = 6'd12;
  localparam logic [5:0] INST_J    = 6'd13;
  localparam logic [5:0] INST_JR   = 6'd14;
  localparam logic [5:0] INST_JAL  = 6'd15;
  localparam logic [5:0] INST_HLT  = 6'd63;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLT = 4'd2;
  localparam logic [3:0] ALU_SRA = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [3:0] {
    CLS_NOP   = 4'd0,
    CLS_HLT   = 4'd1,
    CLS_ALU   = 4'd2,
    CLS_LOAD  = 4'd3,
    CLS_STORE = 4'd4,
    CLS_BEQ   = 4'd5,
    CLS_J     = 4'd6,
    CLS_JR    = 4'd7,
    CLS_JAL   = 4'd8
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [3:0] alu_op;
    logic       alu_srcb;
    logic       imm_zext;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       mem_byte;
    logic       is_addi;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_ctrl_decode.sv
// Per-instruction control decode: maps an instruction code to its class and the
// datapath controls that stay fixed while the instruction executes.
module ctrl_decode
  import mc_controller_pkg::*;
(
  input  logic [5:0] dec_inst,
  output ctrl_t      ctrl
);

  // Instruction code to control bundle; unknown codes behave as NOP.
  always_comb begin
    ctrl.cls      = CLS_NOP;
    ctrl.alu_op   = ALU_ADD;
    ctrl.alu_srcb = 1'b0;
    ctrl.imm_zext = 1'b0;
    ctrl.reg_dst  = RD_RT;
    ctrl.wb_src   = WB_ALU;
    ctrl.mem_byte = 1'b0;
    ctrl.is_addi  = 1'b0;
    case (dec_inst)
      INST_NOP:  ctrl.cls = CLS_NOP;
      INST_HLT:  ctrl.cls = CLS_HLT;
      INST_ADDU: begin ctrl.cls = CLS_ALU; ctrl.reg_dst = RD_RD; end
      INST_SUBU: begin ctrl.cls = CLS_ALU; ctrl.reg_dst = RD_RD; ctrl.alu_op = ALU_SUB; end
      INST_SLT:  begin ctrl.cls = CLS_ALU; ctrl.reg_dst = RD_RD; ctrl.alu_op = ALU_SLT; end
      INST_SRAV: begin ctrl.cls = CLS_ALU; ctrl.reg_dst = RD_RD; ctrl.alu_op = ALU_SRA; end
      INST_ADDI: begin ctrl.cls = CLS_ALU; ctrl.alu_srcb = 1'b1; ctrl.is_addi = 1'b1; end
      INST_ORI: begin
        ctrl.cls = CLS_ALU; ctrl.alu_op = ALU_OR; ctrl.alu_srcb = 1'b1; ctrl.imm_zext = 1'b1;
      end
      INST_LUI: begin
        ctrl.cls = CLS_ALU; ctrl.alu_op = ALU_LUI; ctrl.alu_srcb = 1'b1; ctrl.imm_zext = 1'b1;
      end
      INST_LW:   begin ctrl.cls = CLS_LOAD; ctrl.alu_srcb = 1'b1; ctrl.wb_src = WB_MEM; end
      INST_LB: begin
        ctrl.cls = CLS_LOAD; ctrl.alu_srcb = 1'b1; ctrl.wb_src = WB_MEM; ctrl.mem_byte = 1'b1;
      end
      INST_SW:   begin ctrl.cls = CLS_STORE; ctrl.alu_srcb = 1'b1; end
      INST_SB:   begin ctrl.cls = CLS_STORE; ctrl.alu_srcb = 1'b1; ctrl.mem_byte = 1'b1; end
      INST_BEQ:  begin ctrl.cls = CLS_BEQ; ctrl.alu_op = ALU_SUB; end
      INST_J:    ctrl.cls = CLS_J;
      INST_JR:   ctrl.cls = CLS_JR;
      INST_JAL:  begin ctrl.cls = CLS_JAL; ctrl.reg_dst = RD_RA; ctrl.wb_src = WB_PC4; end
      default:   ctrl.cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// handshake, datapath enables and a retired-instruction counter.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       dec_inst,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_byte,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic [3:0]       alu_op,
  output logic             alu_srcb,
  output logic             imm_zext,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_r;
  state_e           next_s;
  logic             retire_s;
  ctrl_t            ctrl_s;
  logic [CNT_W-1:0] cnt_r;

  ctrl_decode u_ctrl_decode (
    .dec_inst (dec_inst),
    .ctrl     (ctrl_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RST;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state selection and retire detection.
  always_comb begin
    next_s   = state_r;
    retire_s = 1'b0;
    case (state_r)
      ST_RST:   next_s = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) next_s = ST_DECODE;
        else           next_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (ctrl_s.cls)
          CLS_NOP: begin next_s = ST_FETCH; retire_s = 1'b1; end
          CLS_HLT: begin next_s = ST_HALT;  retire_s = 1'b1; end
          default: next_s = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (ctrl_s.cls)
          CLS_BEQ, CLS_J, CLS_JR: begin next_s = ST_FETCH; retire_s = 1'b1; end
          CLS_LOAD, CLS_STORE:    next_s = ST_MEM;
          default:                next_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready) begin
          next_s = ST_MEM;
        end else if (ctrl_s.cls == CLS_STORE) begin
          next_s   = ST_FETCH;
          retire_s = 1'b1;
        end else begin
          next_s = ST_WB;
        end
      end
      ST_WB:   begin next_s = ST_FETCH; retire_s = 1'b1; end
      ST_HALT: next_s = ST_HALT;
      default: next_s = ST_RST;
    endcase
  end

  // Datapath controls; ALU controls stay asserted from EXEC through WB.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_byte = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    pc_src   = PC_PLUS4;
    reg_dst  = RD_RT;
    wb_src   = WB_ALU;
    alu_op   = ALU_ADD;
    alu_srcb = 1'b0;
    imm_zext = 1'b0;
    halted   = 1'b0;
    if ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB)) begin
      alu_op   = ctrl_s.alu_op;
      alu_srcb = ctrl_s.alu_srcb;
      imm_zext = ctrl_s.imm_zext;
    end else begin
      alu_op   = ALU_ADD;
    end
    case (state_r)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      ST_EXEC: begin
        case (ctrl_s.cls)
          CLS_BEQ: begin pc_we = alu_zero; pc_src = PC_BRANCH; end
          CLS_J:   begin pc_we = 1'b1;     pc_src = PC_JUMP;   end
          CLS_JR:  begin pc_we = 1'b1;     pc_src = PC_RS;     end
          CLS_JAL: begin pc_we = 1'b1;     pc_src = PC_JUMP;   end
          default: pc_we = 1'b0;
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we   = (ctrl_s.cls == CLS_STORE);
        mem_byte = ctrl_s.mem_byte;
      end
      ST_WB: begin
        reg_we  = ~(ctrl_s.is_addi & alu_ovf);
        reg_dst = ctrl_s.reg_dst;
        wb_src  = ctrl_s.wb_src;
      end
      ST_HALT: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (retire_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign instr_cnt = cnt_r;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port dec_inst  input  6  decoded instruction code from the instruction decoder, driven from the IR.
REQ-005 SHALL have port alu_zero  input  1  ALU result equals zero.
REQ-006 SHALL have port alu_ovf  input  1  signed-add overflow, meaningful for ADDI only.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current request this cycle.
REQ-008 SHALL have port mem_req  output  1  memory request, held until mem_ready.
REQ-009 SHALL have port mem_we / mem_byte / iord  output  1 each  store, byte access, data-address select (0 = PC).
REQ-010 SHALL have port ir_we / pc_we / reg_we  output  1 each  IR, PC and register-file write enables.
REQ-011 SHALL have port pc_src  output  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
REQ-012 SHALL have port reg_dst / wb_src  output  2 each  destination (0 = rt, 1 = rd, 2 = $31) and writeback source (0 = ALU, 1 = mem, 2 = PC+4).
REQ-013 SHALL have port alu_op  output  4  ALU operation code; alu_srcb  output  1  0 = rt, 1 = immediate; imm_zext  output  1  zero-extend the immediate.
REQ-014 SHALL have port halted  output  1  HLT retired; instr_cnt  output  CNT_W  number of retired instructions.

Function
REQ-015 SHALL implement states RST, FETCH, DECODE, EXEC, MEM, WB and HALT in a registered state register; outputs SHALL be combinational from the state and dec_inst.
REQ-016 In RST, every output SHALL be 0; the next state SHALL be FETCH.
REQ-017 In FETCH, SHALL assert mem_req with iord=0; on mem_ready it SHALL assert ir_we and pc_we with pc_src=0 and go to DECODE, and otherwise it SHALL stay in FETCH.
REQ-018 In DECODE, NOP SHALL go to FETCH (retire), HLT SHALL go to HALT (retire), and all other instructions SHALL go to EXEC.
REQ-019 In EXEC, behaviour by instruction class:
- BEQ: pc_we=alu_zero, pc_src=1, then FETCH.
- J: pc_src=2, pc_we=1, then FETCH.
- JR: pc_src=3, pc_we=1, then FETCH.
- JAL: pc_src=2, pc_we=1, then WB.
- Loads/stores: then MEM.
- Otherwise: then WB.
REQ-020 In MEM, SHALL assert mem_req with iord=1; mem_we SHALL be 1 for SW/SB and mem_byte SHALL be 1 for LB/SB.
REQ-021 On mem_ready in MEM, stores SHALL go to FETCH (retire) and loads SHALL go to WB; without mem_ready, MEM SHALL hold with identical outputs.
REQ-022 In WB, reg_we SHALL be 1 except for ADDI with alu_ovf=1, which SHALL suppress the write; the next state SHALL be FETCH (retire).
REQ-023 WB routing:
- Loads: wb_src=1, reg_dst=0.
- JAL: wb_src=2, reg_dst=2.
- R-type (ADDU, SUBU, SLT, SRAV): wb_src=0, reg_dst=1.
- I-type: wb_src=0, reg_dst=0.
REQ-024 alu_op, alu_srcb and imm_zext SHALL be held constant from EXEC through WB; ORI and LUI SHALL use imm_zext=1.
REQ-025 instr_cnt SHALL increment by 1 on every retire edge, SHALL wrap modulo 2^CNT_W, and SHALL count at most one retire per cycle.
REQ-026 HALT SHALL be terminal: halted=1, all enables 0, and exit only by reset.
REQ-027 mem_ready outside FETCH and MEM SHALL be ignored.
REQ-028 mem_ready arriving in the same cycle that mem_req first asserts SHALL complete the access (minimum latency 1 cycle).
REQ-029 Cycle counts with zero memory wait: R-type 4, LW 5, SW 4, BEQ/J/JR 3, JAL 4, NOP 2.

Reset
REQ-030 Asserting rst SHALL force state RST, instr_cnt 0 and all outputs 0 immediately, without waiting for clk, including mid-access in FETCH/MEM.
REQ-031 After rst deasserts, the first mem_req SHALL appear exactly 1 clk edge later.

Structure
REQ-032 INST_* codes, state encodings, ALU op codes and pc_src/reg_dst/wb_src encodings SHALL live in the shared defines file.
REQ-033 SHALL be one module; the per-instruction control decode MAY be a sub-module ctrl_decode (combinational).

Verification
REQ-034 ADDU with mem_ready=1 always: expect FETCH-DECODE-EXEC-WB, reg_we=1, reg_dst=1, wb_src=0 in cycle 4, instr_cnt 0->1.
REQ-035 LW with mem_ready delayed 3 cycles in MEM: expect mem_req, iord=1 and mem_we=0 held for 4 cycles, then WB with wb_src=1; total 8 cycles.
REQ-036 BEQ twice, alu_zero=1 then 0: expect pc_we=1, pc_src=1 in EXEC the first time, pc_we=0 the second, reg_we never 1.
REQ-037 ADDI with alu_ovf=1: expect reg_we=0 in WB and instr_cnt still incremented.
REQ-038 HLT: expect halted=1 after DECODE and no mem_req for 20 cycles; then rst pulse -> halted=0, instr_cnt=0, mem_req 1 edge after release.
REQ-039 rst asserted mid-MEM on an SB: expect mem_req, mem_we and mem_byte drop to 0 asynchronously before the next clk edge.
